// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a drain interrupt.
// Register map by address[3:2]: 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 CTRL.
//
// Bus handshake: write_enable is a single-cycle strobe already qualified by
// the upstream window decode. Every strobed cycle is accepted on that clk
// edge; there is no back-pressure. A TXDATA push into a full FIFO is dropped
// and recorded in the sticky overflow flag. Reads are combinational, have no
// side effects, and are valid in the same cycle as the address.
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   output logic [31:0] read_data,
   output logic        tx,
   output logic        irq
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // FSM state is kept in a plain named register so checkers can bind to it
   state_t      state, state_next;
   logic [15:0] baud_cnt, baud_cnt_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic [7:0]  shift_reg, shift_reg_next;
   logic        tx_reg, tx_next;
   logic        pop;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic [15:0]      bauddiv;
   logic             tx_enable, irq_enable;

   logic [1:0] sel;
   logic       push_req, push_ok, full, empty, busy;
   logic [7:0] head, count_byte;

   logic unused_bits;
   assign unused_bits = ^{address[31:4], address[1:0], write_data[31:16]};

   assign sel        = address[3:2];
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign empty      = (count == '0);
   assign push_req   = write_enable && (sel == 2'd0);
   assign push_ok    = push_req && !full;
   assign head       = mem[rd_ptr];
   assign busy       = (state != IDLE);
   assign count_byte = 8'(count);
   assign tx         = tx_reg;
   assign irq        = irq_enable && empty && (state == IDLE);

   // FIFO storage: written only by accepted pushes, no reset needed
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= write_data[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push_req && full)
            overflow <= 1'b1;
         else if (write_enable && (sel == 2'd1) && write_data[3])
            overflow <= 1'b0;
      end
   end

   // Configuration registers: baud divisor and control bits
   always_ff @(posedge clk) begin
      if (!rst) begin
         bauddiv    <= DEFAULT_DIV;
         tx_enable  <= 1'b1;
         irq_enable <= 1'b0;
      end else if (write_enable) begin
         if (sel == 2'd2) bauddiv <= write_data[15:0];
         if (sel == 2'd3) begin
            tx_enable  <= write_data[0];
            irq_enable <= write_data[1];
         end
      end
   end

   // Serialiser state register; reset aborts any frame and idles the line
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_reg_next;
         tx_reg    <= tx_next;
      end
   end

   // Serialiser next state; each bit lasts bauddiv+1 cycles, reloaded per bit
   always_comb begin
      state_next     = state;
      baud_cnt_next  = baud_cnt;
      bit_idx_next   = bit_idx;
      shift_reg_next = shift_reg;
      tx_next        = tx_reg;
      pop            = 1'b0;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (tx_enable && !empty) begin
               pop            = 1'b1;
               shift_reg_next = head;
               tx_next        = 1'b0;
               baud_cnt_next  = bauddiv;
               state_next     = START;
            end
         end
         START: begin
            if (baud_cnt == '0) begin
               tx_next       = shift_reg[0];
               bit_idx_next  = 3'd0;
               baud_cnt_next = bauddiv;
               state_next    = DATA;
            end else begin
               baud_cnt_next = baud_cnt - 16'd1;
            end
         end
         DATA: begin
            if (baud_cnt == '0) begin
               baud_cnt_next = bauddiv;
               if (bit_idx == 3'd7) begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end else begin
                  shift_reg_next = {1'b0, shift_reg[7:1]};
                  tx_next        = shift_reg[1];
                  bit_idx_next   = bit_idx + 3'd1;
               end
            end else begin
               baud_cnt_next = baud_cnt - 16'd1;
            end
         end
         STOP: begin
            if (baud_cnt == '0) begin
               if (tx_enable && !empty) begin
                  // back-to-back: next start bit follows the stop bit directly
                  pop            = 1'b1;
                  shift_reg_next = head;
                  tx_next        = 1'b0;
                  baud_cnt_next  = bauddiv;
                  state_next     = START;
               end else begin
                  tx_next    = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               baud_cnt_next = baud_cnt - 16'd1;
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   // Combinational register read mux
   always_comb begin
      read_data = '0;
      case (sel)
         2'd1: read_data = {16'd0, count_byte, 4'd0, overflow, empty, full, busy};
         2'd2: read_data = {16'd0, bauddiv};
         2'd3: read_data = {30'd0, irq_enable, tx_enable};
         default: read_data = '0;
      endcase
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter, a bus responder on the core's load/store MMIO path, sitting alongside the timer and GPIO in the window 0xFFFF0020-0xFFFF002F. The core initiates single-cycle reads and writes. The block buffers bytes in a TX FIFO and serialises them as 8N1 frames, LSB first, on a registered tx line. An optional interrupt flags that the FIFO has drained.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
DEFAULT_DIV, 16'd867, reset value of BAUDDIV; bit period is BAUDDIV+1 clk cycles.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-low.
address  input  32  byte address from the core ALU; only address[3:2] is decoded, the window is pre-decoded upstream.
write_data  input  32  store data.
write_enable  input  1  store strobe, already gated by window decode.
read_data  output  32  combinational read data for the current address.
tx  output  1  serial out, registered; idle high.
irq  output  1  drain interrupt, level.

Behaviour:
- Register map, by address[3:2]:
  - 0 TXDATA: write pushes write_data[7:0]; reads return 0.
  - 1 STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky; cleared by a write with bit3=1, other bits RO), [15:8] FIFO count, rest 0.
  - 2 BAUDDIV: [15:0] read/write; upper bits read 0.
  - 3 CTRL: bit0 tx_enable, bit1 irq_enable; rest read 0.
- Reads: combinational, no side effects. Writes: take effect on the clk edge where write_enable=1.
- Reset (rst=0 at an edge):
  - tx=1, FSM=IDLE, FIFO empty (pointers and count 0), overflow=0, BAUDDIV=DEFAULT_DIV, CTRL=0x1.
  - irq=0; STATUS reads 0x00000004.
  - Reset mid-frame aborts the frame; tx=1 after that edge.
- FIFO:
  - A push when full (count before the edge = FIFO_DEPTH) is dropped and sets overflow. This holds even if a pop happens the same edge.
  - Simultaneous push and pop when not full: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. baud_cnt counts down from BAUDDIV to 0; a bit ends at the edge where baud_cnt=0.
  - IDLE: when tx_enable=1 and FIFO non-empty, at that edge pop the head into shift_reg, tx<=0, baud_cnt<=BAUDDIV, go to START.
  - START end: tx<=shift_reg[0], bit_idx<=0, go to DATA.
  - DATA end: if bit_idx=7, tx<=1 and go to STOP; else shift right, tx<=next bit, bit_idx+1.
  - STOP end: if tx_enable and FIFO non-empty, pop and go to START with tx<=0 (back-to-back, no idle gap); else go to IDLE with tx=1.
- Frame length is exactly 10*(BAUDDIV+1) cycles.
- Latency: a TXDATA write at edge N with idle FSM and empty FIFO gives tx falling after edge N+1.
- A BAUDDIV write mid-frame applies from the next bit reload; the current bit keeps its old count.
- Clearing tx_enable mid-frame lets the current frame finish; no further pops occur.
- BAUDDIV=0 gives a 1-cycle bit period and must work.
- irq = irq_enable & empty & (FSM==IDLE), decoded from registered state.

Test Plan:
1. Reset: release rst -> tx=1, irq=0; STATUS reads 0x00000004, BAUDDIV reads 867, CTRL reads 0x1.
2. Single frame: write BAUDDIV=3, then TXDATA=0xA5.
   - tx falls one cycle after the TXDATA edge, then shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - busy=1 for the 40 cycles, then STATUS reads 0x4.
3. Back-to-back: with BAUDDIV=3, push 0x01, 0x02, 0x03 on consecutive cycles.
   - Three contiguous frames over 120 cycles with no idle cycle between stop and start.
   - STATUS count steps 2, 1, 0 at each pop.
4. Overflow: with CTRL=0, push 9 bytes.
   - STATUS reads full=1, overflow=1, count=8 (0x0000080A).
   - Write STATUS=0x8 -> overflow=0, count still 8. Set CTRL=1 -> 8 frames transmitted in FIFO order.
5. IRQ: CTRL=0x3, BAUDDIV=1, push one byte.
   - irq=0 during the frame; irq=1 on the cycle after the stop bit ends.
   - A TXDATA push -> irq=0 the following cycle.
6. Reset mid-frame: assert rst for one edge during DATA with 3 bytes queued -> tx=1 the next cycle, STATUS 0x4, and no further frames.
